kws_detect_smoother: RTL and testbench
======================================

Name: kws_detect_smoother

Overview:
- Post-processing stage directly downstream of the CNN keyword-spotting accelerator.
- Consumes the accelerator's per-inference result (keyword_detected / keyword_class) and filters out spurious single-inference hits.
- Emits one confirmed keyword event only after CONFIRM_COUNT consecutive agreeing detections, then enforces a hold-off period so one utterance produces exactly one event.

Parameters:
CLASS_WIDTH, 2, width of keyword class index (matches accelerator OUTPUT_SIZE).
CONFIRM_COUNT, 3, consecutive same-class hits required to fire (legal range 1..15).
TIMEOUT_CYCLES, 32, max idle cycles between det_valid strobes while tracking (>=1).
HOLDOFF_CYCLES, 64, refractory cycles after an event (>=1).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  block enable; low forces IDLE synchronously.
det_valid  input  1  one-cycle strobe: accelerator result is valid this cycle.
det_hit  input  1  accelerator keyword_detected, sampled only when det_valid=1.
det_class  input  CLASS_WIDTH  accelerator keyword_class, sampled only when det_valid=1.
kw_event  output  1  one-cycle pulse: keyword confirmed.
kw_class  output  CLASS_WIDTH  class of most recent event; held until the next event.
holdoff  output  1  high while in HOLDOFF state.
event_count  output  16  number of events since reset, saturating at 16'hFFFF.

Behaviour:
- Reset (async, rst=1): state=IDLE; kw_event=0, kw_class=0, holdoff=0, event_count=0; internal cand_class, match_cnt, gap_cnt, hold_cnt cleared.
- States: IDLE, TRACK, HOLDOFF. All outputs are registered.
- IDLE:
  - det_valid & det_hit: cand_class<=det_class, match_cnt<=1, gap_cnt<=0.
  - If CONFIRM_COUNT==1, fire immediately; else go to TRACK.
  - det_valid & !det_hit: stay in IDLE.
- TRACK, with det_valid=1:
  - det_hit & det_class==cand_class: match_cnt++, gap_cnt<=0. If the new match_cnt==CONFIRM_COUNT, fire.
  - det_hit & det_class!=cand_class: restart with cand_class<=det_class, match_cnt<=1, gap_cnt<=0; stay in TRACK.
  - !det_hit: go to IDLE, clear match_cnt.
- TRACK, with det_valid=0:
  - gap_cnt++. When gap_cnt reaches TIMEOUT_CYCLES, go to IDLE and clear match_cnt.
  - If det_valid arrives in the same cycle the timeout would expire, det_valid wins and is processed as above.
- Fire:
  - In the cycle after the confirming det_valid edge: kw_event=1 for exactly one cycle, kw_class=cand_class, event_count+1 (saturating).
  - State enters HOLDOFF on that same edge, hold_cnt<=HOLDOFF_CYCLES.
  - Latency: confirming strobe at edge N produces kw_event high during N..N+1, i.e. visible one cycle after the strobe.
- HOLDOFF:
  - holdoff=1; all det_valid strobes ignored, no tracking.
  - hold_cnt decrements each cycle; at 0, go to IDLE and drop holdoff.
  - Holdoff is high for exactly HOLDOFF_CYCLES cycles.
  - A det_valid in the first IDLE cycle after HOLDOFF is processed normally.
- enable=0:
  - On the next edge: state=IDLE, match_cnt/gap_cnt/hold_cnt cleared, holdoff=0, no kw_event. Any in-progress HOLDOFF is aborted.
  - kw_class and event_count are preserved.
  - det_valid is ignored while enable=0.
- Widths: match_cnt 4 bits; gap_cnt and hold_cnt sized $clog2(param+1). No overflow possible within legal parameter ranges.
- det_hit and det_class are don't-care when det_valid=0.

Test Plan:
1. Defaults; three strobes det_hit=1, class=2'b01, 4 cycles apart -> one kw_event pulse 1 cycle after 3rd strobe, kw_class=01, event_count=1, holdoff high for 64 cycles.
2. Strobes class 01, 01, 10, 10, 10 -> no event after first two; event with kw_class=10 one cycle after 5th strobe.
3. Two class-01 hits, then 32 idle cycles, then one class-01 hit -> timeout returns to IDLE, no event; two more hits (3 total after restart) -> event.
4. Confirmed event, then 5 class-01 hits during holdoff -> no second event; 3 hits after holdoff ends -> event_count=2.
5. Two hits, then a strobe with det_hit=0 -> IDLE, no event. Then rst pulse mid-HOLDOFF -> all outputs 0 asynchronously.
6. enable deasserted mid-HOLDOFF -> holdoff=0 next cycle, kw_class held. Force event_count to 16'hFFFF (65535 events or fast params) -> stays 16'hFFFF on next event.

Source files
------------

// File: rtl/kws_detect_smoother.sv
// kws_detect_smoother: confirms repeated keyword detections into single events with hold-off
module kws_detect_smoother #(
   parameter int CLASS_WIDTH    = 2,
   parameter int CONFIRM_COUNT  = 3,
   parameter int TIMEOUT_CYCLES = 32,
   parameter int HOLDOFF_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   det_valid,
   input  logic                   det_hit,
   input  logic [CLASS_WIDTH-1:0] det_class,
   output logic                   kw_event,
   output logic [CLASS_WIDTH-1:0] kw_class,
   output logic                   holdoff,
   output logic [15:0]            event_count
);
   localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;
   state_t                 state;
   logic [CLASS_WIDTH-1:0] cand_class;
   logic [3:0]             match_cnt;
   logic [GW-1:0]          gap_cnt;
   logic [HW-1:0]          hold_cnt;
   logic                   same;
   logic                   fire;
   // a hit confirms when it is the CONFIRM_COUNT-th consecutive agreeing hit
   always_comb begin
      same = det_class == cand_class;
      fire = enable && det_valid && det_hit &&
             ((state == IDLE && CONFIRM_COUNT == 1) ||
              (state == TRACK && same && match_cnt + 4'd1 == 4'(CONFIRM_COUNT)));
   end
   // tracking FSM with registered outputs; enable low aborts everything except kw_class/event_count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cand_class  <= '0;
         match_cnt   <= '0;
         gap_cnt     <= '0;
         hold_cnt    <= '0;
         kw_event    <= 1'b0;
         kw_class    <= '0;
         holdoff     <= 1'b0;
         event_count <= '0;
      end else begin
         kw_event <= 1'b0;
         if (!enable) begin
            state     <= IDLE;
            match_cnt <= '0;
            gap_cnt   <= '0;
            hold_cnt  <= '0;
            holdoff   <= 1'b0;
         end else if (fire) begin
            kw_event    <= 1'b1;
            kw_class    <= det_class;
            cand_class  <= det_class;
            event_count <= (event_count == 16'hFFFF) ? event_count : event_count + 16'd1;
            state       <= HOLD;
            hold_cnt    <= HW'(HOLDOFF_CYCLES);
            holdoff     <= 1'b1;
            match_cnt   <= '0;
            gap_cnt     <= '0;
         end else begin
            case (state)
               IDLE: if (det_valid && det_hit) begin
                  cand_class <= det_class;
                  match_cnt  <= 4'd1;
                  gap_cnt    <= '0;
                  state      <= TRACK;
               end
               TRACK: if (det_valid) begin
                  if (!det_hit) begin
                     state     <= IDLE;
                     match_cnt <= '0;
                  end else begin
                     cand_class <= det_class;
                     match_cnt  <= same ? match_cnt + 4'd1 : 4'd1;
                     gap_cnt    <= '0;
                  end
               end else if (gap_cnt == GW'(TIMEOUT_CYCLES - 1)) begin
                  state     <= IDLE;
                  match_cnt <= '0;
                  gap_cnt   <= '0;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
               default: begin
                  hold_cnt <= hold_cnt - HW'(1);
                  if (hold_cnt == HW'(1)) begin
                     state   <= IDLE;
                     holdoff <= 1'b0;
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_kws_detect_smoother.sv
// tb_kws_detect_smoother: scoreboard bench for the keyword detection smoother
module tb_kws_detect_smoother;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic        det_valid = 1'b0;
   logic        det_hit = 1'b0;
   logic [1:0]  det_class = 2'b00;
   logic        kw_event;
   logic [1:0]  kw_class;
   logic        holdoff;
   logic [15:0] event_count;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [15:0] exp_cnt = 16'd0;
   typedef struct {
      logic [1:0]  cls;
      logic [15:0] cnt;
      int          due;
   } exp_t;
   exp_t q[$];
   exp_t e_mon;

   kws_detect_smoother dut (
      .clk(clk), .rst(rst), .enable(enable), .det_valid(det_valid), .det_hit(det_hit),
      .det_class(det_class), .kw_event(kw_event), .kw_class(kw_class), .holdoff(holdoff),
      .event_count(event_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // every kw_event pulse must match the oldest expected event, in value and in cycle
   always @(negedge clk) begin
      if (!rst && kw_event === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kw_class=%0d event_count=%0d cycle=%0d", kw_class, event_count, cyc);
         end else begin
            e_mon = q.pop_front();
            if (kw_class !== e_mon.cls || event_count !== e_mon.cnt || cyc != e_mon.due) begin
               failures++;
               $display("FAIL event_value got class=%0d count=%0d cycle=%0d expected class=%0d count=%0d cycle=%0d",
                        kw_class, event_count, cyc, e_mon.cls, e_mon.cnt, e_mon.due);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic strobe(input logic hit, input logic [1:0] cls, input bit fire);
      det_valid = 1'b1;
      det_hit   = hit;
      det_class = cls;
      if (fire) begin
         exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
         q.push_back('{cls, exp_cnt, cyc + 1});
      end
      @(negedge clk);
      det_valid = 1'b0;
      det_hit   = 1'($urandom);
      det_class = 2'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_holdoff(output int n);
      n = 0;
      while (holdoff === 1'b1 && n < 300) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({kw_event, kw_class, holdoff, event_count} !== 20'd0) begin
         failures++;
         $display("FAIL reset_outputs got ev=%b cls=%0d hold=%b cnt=%0d expected all zero", kw_event, kw_class, holdoff, event_count);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int n;
      strobe(1, 2'b01, 0); idle(3);
      strobe(1, 2'b01, 0); idle(3);
      strobe(1, 2'b01, 1);
      checks++;
      if (holdoff !== 1'b1) begin
         failures++;
         $display("FAIL basic_holdoff_rise got %b expected 1", holdoff);
      end
      wait_holdoff(n);
      checks++;
      if (n != 64) begin
         failures++;
         $display("FAIL basic_holdoff_len got %0d expected 64", n);
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL basic_missing_events got %0d pending expected 0", q.size());
      end
   endtask

   task automatic test_class_change;
      int n;
      strobe(1, 2'b01, 0);
      strobe(1, 2'b01, 0);
      strobe(1, 2'b10, 0);
      strobe(1, 2'b10, 0);
      strobe(1, 2'b10, 1);
      wait_holdoff(n);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL class_change_missing got %0d pending expected 0", q.size());
      end
   endtask

   task automatic test_timeout;
      int n;
      strobe(1, 2'b01, 0);
      strobe(1, 2'b01, 0);
      idle(32);
      strobe(1, 2'b01, 0);
      strobe(1, 2'b01, 0);
      strobe(1, 2'b01, 1);
      wait_holdoff(n);
      strobe(1, 2'b11, 0);
      strobe(1, 2'b11, 0);
      idle(31);
      strobe(1, 2'b11, 1);
      wait_holdoff(n);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL timeout_missing got %0d pending expected 0", q.size());
      end
   endtask

   task automatic test_holdoff_ignore;
      int n;
      strobe(1, 2'b01, 0);
      strobe(1, 2'b01, 0);
      strobe(1, 2'b01, 1);
      repeat (5) begin
         strobe(1, 2'b01, 0);
         idle(2);
      end
      wait_holdoff(n);
      checks++;
      if (n != 64 - 15) begin
         failures++;
         $display("FAIL holdoff_remaining got %0d expected 49", n);
      end
      strobe(1, 2'b01, 0);
      strobe(1, 2'b01, 0);
      strobe(1, 2'b01, 1);
      wait_holdoff(n);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL holdoff_ignore_missing got %0d pending expected 0", q.size());
      end
   endtask

   task automatic test_miss_and_reset;
      strobe(1, 2'b10, 0);
      strobe(1, 2'b10, 0);
      strobe(0, 2'b10, 0);
      strobe(1, 2'b10, 0);
      strobe(1, 2'b10, 0);
      strobe(1, 2'b10, 1);
      idle(10);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({kw_event, kw_class, holdoff, event_count} !== 20'd0) begin
         failures++;
         $display("FAIL async_reset got ev=%b cls=%0d hold=%b cnt=%0d expected all zero", kw_event, kw_class, holdoff, event_count);
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL miss_missing got %0d pending expected 0", q.size());
      end
      q.delete();
      exp_cnt = 16'd0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_enable_and_saturate;
      int n;
      strobe(1, 2'b10, 0);
      strobe(1, 2'b10, 0);
      strobe(1, 2'b10, 1);
      idle(5);
      enable = 1'b0;
      @(negedge clk);
      checks++;
      if (holdoff !== 1'b0 || kw_class !== 2'b10 || event_count !== exp_cnt) begin
         failures++;
         $display("FAIL disable got hold=%b cls=%0d cnt=%0d expected hold=0 cls=2 cnt=%0d", holdoff, kw_class, event_count, exp_cnt);
      end
      repeat (3) strobe(1, 2'b01, 0);
      enable = 1'b1;
      strobe(1, 2'b01, 0);
      strobe(1, 2'b01, 0);
      strobe(1, 2'b01, 1);
      wait_holdoff(n);
      force dut.event_count = 16'hFFFE;
      @(negedge clk);
      release dut.event_count;
      exp_cnt = 16'hFFFE;
      @(negedge clk);
      strobe(1, 2'b11, 0);
      strobe(1, 2'b11, 0);
      strobe(1, 2'b11, 1);
      wait_holdoff(n);
      strobe(1, 2'b00, 0);
      strobe(1, 2'b00, 0);
      strobe(1, 2'b00, 1);
      wait_holdoff(n);
      checks++;
      if (event_count !== 16'hFFFF) begin
         failures++;
         $display("FAIL saturate got %h expected ffff", event_count);
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL enable_missing got %0d pending expected 0", q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_class_change();
      test_timeout();
      test_holdoff_ignore();
      test_miss_and_reset();
      test_enable_and_saturate();
      idle(4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
